// File: rtl/conv_router.sv
// conv_router: steps one conv layer's (output row, column tile, kernel-row slab) space once per clk,
// emitting input-row lanes, the input-column fetch window, zero-pad counts and the output column range.
module conv_router #(
   parameter int OX_TILE = 16,
   parameter int LANES   = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [3:0]  k,
   input  logic [3:0]  s,
   input  logic [3:0]  p,
   input  logic [15:0] ox,
   input  logic [15:0] oy,
   input  logic [15:0] ix,
   input  logic [15:0] iy,
   output logic [3:0]  west_pad,
   output logic [3:0]  slab_num,
   output logic [3:0]  east_pad,
   output logic [15:0] row_idx1,
   output logic [15:0] row_idx2,
   output logic [15:0] row_idx3,
   output logic [15:0] row_start_idx,
   output logic [15:0] row_end_idx,
   output logic [15:0] reg_start_idx,
   output logic [15:0] reg_end_idx,
   output logic        conv_end
);

   localparam logic signed [23:0] TW = 24'(OX_TILE);

   typedef enum logic {IDLE, RUN} state_t;

   typedef struct packed {
      logic [3:0]                  west;
      logic [3:0]                  slab;
      logic [3:0]                  east;
      logic [LANES-1:0][15:0]      rows;
      logic [15:0]                 rs;
      logic [15:0]                 re;
      logic [15:0]                 gs;
      logic [15:0]                 ge;
   } step_t;

   function automatic step_t calc(input logic [3:0] ck, cs, cp, cg,
                                  input logic [15:0] cox, cix, ciy, cy, ct);
      logic signed [23:0] sk, ss, sp, oxs, oxe, xlo, xhi, ixm, ep, base, r;
      step_t o;
      sk   = signed'(24'(ck));
      ss   = signed'(24'(cs));
      sp   = signed'(24'(cp));
      oxs  = signed'(24'(ct)) * TW;
      oxe  = ((oxs + TW > signed'(24'(cox))) ? signed'(24'(cox)) : oxs + TW) - 24'sd1;
      xlo  = oxs * ss - sp;
      xhi  = oxe * ss - sp + sk - 24'sd1;
      ixm  = signed'(24'(cix)) - 24'sd1;
      ep   = xhi - ixm;
      o.west = xlo >= 0 ? 4'd0 : (xlo < -24'sd15 ? 4'd15 : 4'(-xlo));
      o.east = ep <= 0 ? 4'd0 : (ep > 24'sd15 ? 4'd15 : 4'(ep));
      o.rs   = xlo < 0 ? 16'd0 : xlo[15:0];
      o.re   = xhi < ixm ? xhi[15:0] : ixm[15:0];
      o.gs   = oxs[15:0];
      o.ge   = oxe[15:0];
      o.slab = cg;
      base = signed'(24'(cy)) * ss - sp + signed'(24'(cg)) * 24'sd3;
      // a lane is padding if its kernel row is beyond k or its input row falls off the map
      for (int n = 0; n < LANES; n++) begin
         r = base + signed'(24'(n));
         o.rows[n] = (signed'(24'(cg)) * 24'sd3 + signed'(24'(n)) >= sk || r < 0 ||
                      r >= signed'(24'(ciy))) ? 16'hFFFF : r[15:0];
      end
      return o;
   endfunction

   state_t      state;
   logic [3:0]  k_q, s_q, p_q, g, ck, cs, cp, ng;
   logic [15:0] ox_q, oy_q, ix_q, iy_q, y, t, cox, coy, cix, ciy, ny, nt;
   logic        run, last_g, last_t, fin, degen;
   step_t       nxt, cur;

   always_comb begin
      run    = state == RUN;
      ck     = run ? k_q : k;
      cs     = run ? s_q : s;
      cp     = run ? p_q : p;
      cox    = run ? ox_q : ox;
      coy    = run ? oy_q : oy;
      cix    = run ? ix_q : ix;
      ciy    = run ? iy_q : iy;
      last_g = 8'(g) * 8'd3 + 8'd3 >= 8'(k_q);
      last_t = 32'(t) * 32'(OX_TILE) + 32'(OX_TILE) >= 32'(ox_q);
      ng     = (!run || last_g) ? 4'd0 : g + 4'd1;
      nt     = (!run || (last_g && last_t)) ? 16'd0 : (last_g ? t + 16'd1 : t);
      ny     = !run ? 16'd0 : ((last_g && last_t) ? y + 16'd1 : y);
      fin    = 8'(ng) * 8'd3 + 8'd3 >= 8'(ck) &&
               32'(nt) * 32'(OX_TILE) + 32'(OX_TILE) >= 32'(cox) && ny == coy - 16'd1;
      degen  = ck == 4'd0 || cs == 4'd0 || cox == 16'd0 || coy == 16'd0;
      nxt    = calc(ck, cs, cp, ng, cox, cix, ciy, ny, nt);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         {k_q, s_q, p_q} <= '0;
         {ox_q, oy_q, ix_q, iy_q} <= '0;
         {y, t, g} <= '0;
         cur      <= '0;
         conv_end <= 1'b0;
      end else if (state == IDLE) begin
         conv_end <= 1'b0;
         if (en) begin
            {k_q, s_q, p_q} <= {k, s, p};
            {ox_q, oy_q, ix_q, iy_q} <= {ox, oy, ix, iy};
            {y, t, g} <= '0;
            cur      <= degen ? '0 : nxt;
            conv_end <= degen || fin;
            state    <= (degen || fin) ? IDLE : RUN;
         end
      end else begin
         {y, t, g} <= {ny, nt, ng};
         cur      <= nxt;
         conv_end <= fin;
         state    <= fin ? IDLE : RUN;
      end
   end

   assign west_pad      = cur.west;
   assign slab_num      = cur.slab;
   assign east_pad      = cur.east;
   assign row_idx1      = cur.rows[0];
   assign row_idx2      = cur.rows[1];
   assign row_idx3      = cur.rows[2];
   assign row_start_idx = cur.rs;
   assign row_end_idx   = cur.re;
   assign reg_start_idx = cur.gs;
   assign reg_end_idx   = cur.ge;

endmodule

// File: tb/tb_conv_router.sv
// tb_conv_router: directed-vector bench for conv_router with hand-computed expectations.
module tb_conv_router;

   logic        clk, reset, en;
   logic [3:0]  k, s, p;
   logic [15:0] ox, oy, ix, iy;
   logic [3:0]  west_pad, slab_num, east_pad;
   logic [15:0] row_idx1, row_idx2, row_idx3, row_start_idx, row_end_idx, reg_start_idx, reg_end_idx;
   logic        conv_end;
   int          n_assert = 0;
   int          n_fail = 0;

   conv_router dut (
      .clk(clk), .reset(reset), .en(en), .k(k), .s(s), .p(p),
      .ox(ox), .oy(oy), .ix(ix), .iy(iy),
      .west_pad(west_pad), .slab_num(slab_num), .east_pad(east_pad),
      .row_idx1(row_idx1), .row_idx2(row_idx2), .row_idx3(row_idx3),
      .row_start_idx(row_start_idx), .row_end_idx(row_end_idx),
      .reg_start_idx(reg_start_idx), .reg_end_idx(reg_end_idx),
      .conv_end(conv_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_step(input string tag, input int r1, r2, r3, rs, re, gs, ge, w, e, sl);
      chk({tag, ".row1"}, int'(row_idx1), r1);
      chk({tag, ".row2"}, int'(row_idx2), r2);
      chk({tag, ".row3"}, int'(row_idx3), r3);
      chk({tag, ".col_s"}, int'(row_start_idx), rs);
      chk({tag, ".col_e"}, int'(row_end_idx), re);
      chk({tag, ".reg_s"}, int'(reg_start_idx), gs);
      chk({tag, ".reg_e"}, int'(reg_end_idx), ge);
      chk({tag, ".west"}, int'(west_pad), w);
      chk({tag, ".east"}, int'(east_pad), e);
      chk({tag, ".slab"}, int'(slab_num), sl);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; en = 1'b0;
      k = 4'd0; s = 4'd0; p = 4'd0; ox = 16'd0; oy = 16'd0; ix = 16'd0; iy = 16'd0;
      repeat (3) tick();
      chk_step("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst.end", int'(conv_end), 0);
      reset = 1'b1;
      repeat (6) tick();
      chk_step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("idle.end", int'(conv_end), 0);

      // k=6 s=2 p=2 64x64 out, 128x128 in: 64 rows * 4 tiles * 2 slabs = 512 steps
      k = 4'd6; s = 4'd2; p = 4'd2; ox = 16'd64; oy = 16'd64; ix = 16'd128; iy = 16'd128;
      en = 1'b1;
      tick();
      en = 1'b0;
      for (int i = 0; i < 512; i++) begin
         chk($sformatf("big.end%0d", i), int'(conv_end), (i == 511) ? 1 : 0);
         if (i == 0)   chk_step("big.s0", 'hFFFF, 'hFFFF, 0, 0, 33, 0, 15, 2, 0, 0);
         if (i == 1)   chk_step("big.s1", 1, 2, 3, 0, 33, 0, 15, 2, 0, 1);
         if (i == 7)   chk_step("big.s7", 1, 2, 3, 94, 127, 48, 63, 0, 2, 1);
         if (i == 11)  chk_step("big.s11", 3, 4, 5, 30, 65, 16, 31, 0, 0, 1);
         if (i == 511) chk_step("big.s511", 127, 'hFFFF, 'hFFFF, 94, 127, 48, 63, 0, 2, 1);
         if (i == 10) begin
            en = 1'b1; ox = 16'd16; k = 4'd3;
         end
         if (i == 11) begin
            en = 1'b0; ox = 16'd64; k = 4'd6;
         end
         if (i < 511) tick();
      end
      tick();
      chk("big.hold_end", int'(conv_end), 0);
      chk_step("big.hold", 127, 'hFFFF, 'hFFFF, 94, 127, 48, 63, 0, 2, 1);

      // k=3 s=1 p=1 ox=ix=20 oy=iy=4: 2 tiles, 1 slab, 8 steps
      k = 4'd3; s = 4'd1; p = 4'd1; ox = 16'd20; oy = 16'd4; ix = 16'd20; iy = 16'd4;
      en = 1'b1;
      tick();
      en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("sm.end%0d", i), int'(conv_end), (i == 7) ? 1 : 0);
         if (i == 0) chk_step("sm.s0", 'hFFFF, 0, 1, 0, 16, 0, 15, 1, 0, 0);
         if (i == 1) chk_step("sm.s1", 'hFFFF, 0, 1, 15, 19, 16, 19, 0, 1, 0);
         if (i == 7) chk_step("sm.s7", 2, 3, 'hFFFF, 15, 19, 16, 19, 0, 1, 0);
         if (i < 7) tick();
      end
      tick();
      chk("sm.hold_end", int'(conv_end), 0);
      chk("sm.hold_row1", int'(row_idx1), 2);

      // asynchronous abort mid-run, then restart from step 0
      en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      tick();
      #3;
      reset = 1'b0;
      #1;
      chk_step("abort", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("abort.end", int'(conv_end), 0);
      repeat (10) tick();
      chk("abort.end_late", int'(conv_end), 0);
      chk("abort.reg_e_late", int'(reg_end_idx), 0);
      reset = 1'b1;
      tick();
      en = 1'b1;
      tick();
      en = 1'b0;
      chk_step("restart.s0", 'hFFFF, 0, 1, 0, 16, 0, 15, 1, 0, 0);
      chk("restart.end", int'(conv_end), 0);
      repeat (7) tick();
      chk("restart.end7", int'(conv_end), 1);
      tick();

      // degenerate k=0: single conv_end pulse with zeroed outputs
      k = 4'd0;
      en = 1'b1;
      tick();
      en = 1'b0;
      chk("degen.end", int'(conv_end), 1);
      chk_step("degen", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("degen.end_next", int'(conv_end), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
